// File: rtl/window_gen_3x3.sv
// ----------------------------------------------------------------------------
// window_gen_3x3
//   Sliding 3x3 window generator over a raster-order 8-bit pixel stream.
//   Two line buffers hold the previous two lines; a 3x3 register array is
//   shifted left on every accepted pixel and refilled from the line buffers
//   and the incoming pixel.
//
// Parameters
//   IMG_WIDTH   pixels per line (3..4096)
//   IMG_HEIGHT  lines per frame (3..4096)
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    pixel accepted on any edge where high (no backpressure)
//   in_pixel    8-bit raster-order pixel
//   out_valid   w0..w8 hold a complete window (one cycle per window)
//   w0..w8      window, row-major, w0 top-left, w8 newest pixel
//   frame_done  pulse alongside the window ending at the last pixel of a frame
// ----------------------------------------------------------------------------
module window_gen_3x3 #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_pixel,
    output logic       out_valid,
    output logic [7:0] w0,
    output logic [7:0] w1,
    output logic [7:0] w2,
    output logic [7:0] w3,
    output logic [7:0] w4,
    output logic [7:0] w5,
    output logic [7:0] w6,
    output logic [7:0] w7,
    output logic [7:0] w8,
    output logic       frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // lb1 holds line row-1, lb2 holds line row-2, both indexed by column
    logic [7:0] lb1 [IMG_WIDTH];
    logic [7:0] lb2 [IMG_WIDTH];

    logic accept;
    logic last_col;
    logic last_row;

    assign accept   = in_valid & ~rst;
    assign last_col = (col == CW'(IMG_WIDTH - 1));
    assign last_row = (row == RW'(IMG_HEIGHT - 1));

    // Line buffers are never cleared; stale contents only reach w0..w5 for
    // rows 0 and 1, where out_valid is held low.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= in_pixel;
            lb2[col] <= lb1[col];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            w0 <= '0; w1 <= '0; w2 <= '0;
            w3 <= '0; w4 <= '0; w5 <= '0;
            w6 <= '0; w7 <= '0; w8 <= '0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (in_valid) begin
                w0 <= w1; w1 <= w2; w2 <= lb2[col];
                w3 <= w4; w4 <= w5; w5 <= lb1[col];
                w6 <= w7; w7 <= w8; w8 <= in_pixel;

                // Windows touching col 0/1 would straddle a line wrap and
                // rows 0/1 a frame wrap, so both are gated out here.
                out_valid  <= (row >= RW'(2)) && (col >= CW'(2));
                frame_done <= last_col && last_row;

                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

endmodule
